ifetch_queue: RTL

Instruction fetch stage upstream of the single-cycle datapath. Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch FIFO. Delivers `{inst_pc, inst}` to the datapath through a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses from the old stream.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/ifetch_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch queue
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, data} with flush and a registered head
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] kept;
  logic          do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  assign kept       = count - CW'(do_pop);
  assign count_nxt  = kept + CW'(push);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // head mirrors mem[rd_ptr] one cycle ahead so the output never depends on pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt == '0) begin
        head <= '0;
      end else if (kept == '0) begin
        head <= push_data;
      end else begin
        head <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential fetch address generation, credit-limited issue, redirect flush
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   live_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW+1:0]   credits_used;
  logic            fifo_full;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_live;
  logic            pop;
  logic            push;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // occupancy plus every outstanding response must fit in the FIFO
  assign credits_used   = {2'b00, fifo_count} + {2'b00, live_cnt} + {2'b00, drop_cnt};
  assign imem_req_valid = !reset && !redirect && (credits_used < (CW+2)'(DEPTH));
  assign imem_req_addr  = reset ? RESET_PC : fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (live_cnt != '0);

  assign inst_valid = !reset && !fifo_empty;
  assign inst       = reset ? '0 : head.data;
  assign inst_pc    = reset ? '0 : head.pc;
  assign pop        = inst_valid && inst_ready;

  assign push       = rsp_live && !redirect && (!fifo_full || pop);
  assign push_entry = '{pc: rsp_pc, data: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // a response arriving now retires one pending slot of the old stream
      fetch_pc <= align_pc(redirect_pc);
      rsp_pc   <= align_pc(redirect_pc);
      live_cnt <= '0;
      drop_cnt <= drop_cnt + live_cnt - CW'(rsp_drop || rsp_live);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (rsp_live) begin
        rsp_pc <= rsp_pc + PC_STEP;
      end
      live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_live);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
  end

endmodule
